// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES round sequencer: FSM state encoding,
// default round count and the key-schedule round-constant update.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADING,
        ST_ROUND0,
        ST_ROUND,
        ST_DONE
    } state_t;

    localparam int         NROUNDS_DEF = 10;
    localparam logic [7:0] RCON_POLY   = 8'h1B;

    // Multiply by x in GF(2^8), reducing modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Control bus between the SPI/datapath side and the round sequencer.
// The master side owns load; the sequencer (slave) drives the round controls.
interface aes_round_sequencer_if;
    logic       load;
    logic [3:0] round;
    logic       init_en;
    logic       commit;
    logic       last_round;
    logic [7:0] rcon;
    logic       busy;
    logic       done;

    modport master (
        output load,
        input  round, init_en, commit, last_round, rcon, busy, done
    );

    modport slave (
        input  load,
        output round, init_en, commit, last_round, rcon, busy, done
    );
endinterface

// File: rtl/aes_seq_nextstate.sv
// Combinational next-state, round-counter, wait-counter and rcon logic for
// the AES round sequencer; the registers live in the top level.
module aes_seq_nextstate
    import aes_pkg::*;
#(
    parameter int SBOX_LAT = 2,
    parameter int NROUNDS  = NROUNDS_DEF
) (
    input  state_t     i_state,
    input  logic [3:0] i_round,
    input  logic [2:0] i_wait_cnt,
    input  logic [7:0] i_rcon,
    input  logic       i_load,
    output state_t     o_state,
    output logic [3:0] o_round,
    output logic [2:0] o_wait_cnt,
    output logic [7:0] o_rcon
);

    localparam logic [2:0] LAT = 3'(SBOX_LAT);
    localparam logic [3:0] NR  = 4'(NROUNDS);

    always_comb begin
        o_state    = i_state;
        o_round    = i_round;
        o_wait_cnt = i_wait_cnt;
        o_rcon     = i_rcon;

        unique case (i_state)
            ST_IDLE: begin
                o_round    = 4'd0;
                o_wait_cnt = 3'd0;
                o_rcon     = 8'h00;
                if (i_load) o_state = ST_LOADING;
            end
            ST_LOADING: begin
                o_round    = 4'd0;
                o_wait_cnt = 3'd0;
                o_rcon     = 8'h00;
                if (!i_load) o_state = ST_ROUND0;
            end
            ST_ROUND0: begin
                o_state    = ST_ROUND;
                o_round    = 4'd1;
                o_wait_cnt = 3'd0;
                o_rcon     = 8'h01;
            end
            ST_ROUND: begin
                if (i_wait_cnt == LAT) begin
                    o_wait_cnt = 3'd0;
                    if (i_round < NR) begin
                        o_round = i_round + 4'd1;
                        o_rcon  = xtime(i_rcon);
                    end else begin
                        o_state = ST_DONE;
                        o_rcon  = 8'h00;
                    end
                end else begin
                    o_wait_cnt = i_wait_cnt + 3'd1;
                end
            end
            ST_DONE: begin
                o_wait_cnt = 3'd0;
                o_rcon     = 8'h00;
            end
            default: begin
                o_state    = ST_IDLE;
                o_round    = 4'd0;
                o_wait_cnt = 3'd0;
                o_rcon     = 8'h00;
            end
        endcase

        // A new load wins over everything, including a commit in this cycle.
        if (i_load && (i_state == ST_ROUND0 || i_state == ST_ROUND || i_state == ST_DONE)) begin
            o_state    = ST_LOADING;
            o_round    = 4'd0;
            o_wait_cnt = 3'd0;
            o_rcon     = 8'h00;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: steps an iterative datapath through round 0 and
// NROUNDS S-box-latency-stretched rounds after the SPI host finishes loading.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int SBOX_LAT = 2,
    parameter int NROUNDS  = NROUNDS_DEF
) (
    input  logic                  clk,
    input  logic                  nreset,
    aes_round_sequencer_if.slave  bus
);

    localparam logic [2:0] LAT = 3'(SBOX_LAT);
    localparam logic [3:0] NR  = 4'(NROUNDS);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_round;
    logic [3:0] w_next_round;
    logic [2:0] r_wait_cnt;
    logic [2:0] w_next_wait_cnt;
    logic [7:0] r_rcon;
    logic [7:0] w_next_rcon;

    aes_seq_nextstate #(
        .SBOX_LAT (SBOX_LAT),
        .NROUNDS  (NROUNDS)
    ) u_nextstate (
        .i_state    (r_state),
        .i_round    (r_round),
        .i_wait_cnt (r_wait_cnt),
        .i_rcon     (r_rcon),
        .i_load     (bus.load),
        .o_state    (w_next_state),
        .o_round    (w_next_round),
        .o_wait_cnt (w_next_wait_cnt),
        .o_rcon     (w_next_rcon)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_round    <= 4'd0;
            r_wait_cnt <= 3'd0;
            r_rcon     <= 8'h00;
        end else begin
            r_state    <= w_next_state;
            r_round    <= w_next_round;
            r_wait_cnt <= w_next_wait_cnt;
            r_rcon     <= w_next_rcon;
        end
    end

    // Controls decode only registered state, so load never reaches them combinationally.
    assign bus.round      = r_round;
    assign bus.rcon       = r_rcon;
    assign bus.init_en    = (r_state == ST_ROUND0);
    assign bus.commit     = (r_state == ST_ROUND) && (r_wait_cnt == LAT);
    assign bus.last_round = (r_state == ST_ROUND) && (r_round == NR);
    assign bus.busy       = (r_state == ST_ROUND0) || (r_state == ST_ROUND);
    assign bus.done       = (r_state == ST_DONE);

endmodule
